// File: rtl/axi_instr_write_slave.sv
// rtl/axi_instr_write_slave.sv - AXI4 write slave feeding buffered instructions to the accelerator
module axi_instr_write_slave #(
  parameter int ID_W       = 12,
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 128,
  parameter int INSTR_W    = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_awvalid,
  output logic                          s_awready,
  input  logic [ID_W-1:0]               s_awid,
  input  logic [ADDR_W-1:0]             s_awaddr,
  input  logic [7:0]                    s_awlen,
  input  logic                          s_wvalid,
  output logic                          s_wready,
  input  logic [DATA_W-1:0]             s_wdata,
  input  logic [DATA_W/8-1:0]           s_wstrb,
  input  logic                          s_wlast,
  output logic                          s_bvalid,
  input  logic                          s_bready,
  output logic [ID_W-1:0]               s_bid,
  output logic [1:0]                    s_bresp,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [INSTR_W-1:0]            instr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          drop_err
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ISTRB_W = INSTR_W / 8;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  state_t state, state_nxt;

  logic [ID_W-1:0]    id_q;
  logic [7:0]         len_q;
  logic [8:0]         beat_cnt;
  logic               err_q;
  logic [INSTR_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_full, aw_hs, w_hs, strb_ok, push, pop;

  // Address and the data/strobe bytes above the instruction slot carry nothing we route on.
  logic unused_bits;
  assign unused_bits = ^{s_awaddr, s_wdata[DATA_W-1:INSTR_W], s_wstrb[DATA_W/8-1:ISTRB_W]};

  assign fifo_full   = (count == CNT_W'(FIFO_DEPTH));
  assign aw_hs       = s_awvalid && s_awready;
  assign w_hs        = s_wvalid && s_wready;
  assign strb_ok     = &s_wstrb[ISTRB_W-1:0];
  assign push        = w_hs && strb_ok;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr_data  = mem[rd_ptr];
  assign fifo_count  = count;
  assign s_bid       = id_q;
  assign s_bresp     = {err_q, 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    case (state)
      IDLE: begin
        s_awready = 1'b1;
        if (s_awvalid) state_nxt = DATA;
      end
      DATA: begin
        s_wready = !fifo_full;
        if (s_wvalid && !fifo_full && s_wlast) state_nxt = RESP;
      end
      RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping: err covers both dropped beats and a wlast that disagrees with awlen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q     <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      if (aw_hs) begin
        id_q     <= s_awid;
        len_q    <= s_awlen;
        beat_cnt <= '0;
        err_q    <= 1'b0;
      end else if (w_hs) begin
        beat_cnt <= beat_cnt + 9'd1;
        if (!strb_ok || (s_wlast && beat_cnt != {1'b0, len_q})) err_q <= 1'b1;
      end
      if (w_hs && !strb_ok) drop_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_wdata[INSTR_W-1:0];
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_instr_write_slave.sv
// tb/tb_axi_instr_write_slave.sv - directed self-checking bench for axi_instr_write_slave
module tb_axi_instr_write_slave;
  logic         clk = 1'b0;
  logic         reset;
  logic         s_awvalid, s_awready;
  logic [11:0]  s_awid;
  logic [63:0]  s_awaddr;
  logic [7:0]   s_awlen;
  logic         s_wvalid, s_wready;
  logic [127:0] s_wdata;
  logic [15:0]  s_wstrb;
  logic         s_wlast;
  logic         s_bvalid, s_bready;
  logic [11:0]  s_bid;
  logic [1:0]   s_bresp;
  logic         instr_valid, instr_ready;
  logic [31:0]  instr_data;
  logic [3:0]   fifo_count;
  logic         drop_err;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  axi_instr_write_slave dut (
    .clk(clk), .reset(reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .fifo_count(fifo_count), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Every instruction leaving the FIFO must match the next one the bench pushed.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) check("stream_unexpected", {32'h0, instr_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        else check("stream_order", {32'h0, instr_data}, {32'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic aw(input logic [11:0] id, input logic [7:0] len);
    int n = 0;
    s_awvalid = 1'b1; s_awid = id; s_awlen = len; s_awaddr = 64'h8000_0000_0000_1000;
    while (!s_awready && n < 50) begin @(negedge clk); n++; end
    check("aw_ready", s_awready, 1);
    @(negedge clk);
    s_awvalid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic [15:0] strb, input logic last);
    int n = 0;
    s_wvalid = 1'b1; s_wdata = {96'hDEAD_BEEF_CAFE_F00D_0123_4567, d}; s_wstrb = strb; s_wlast = last;
    while (!s_wready && n < 200) begin @(negedge clk); n++; end
    check("w_ready", s_wready, 1);
    if (&strb[3:0]) exp_q.push_back(d);
    @(negedge clk);
    s_wvalid = 1'b0; s_wlast = 1'b0;
  endtask

  task automatic resp(input logic [11:0] id, input logic [1:0] rsp);
    int n = 0;
    s_bready = 1'b1;
    while (!s_bvalid && n < 50) begin @(negedge clk); n++; end
    check("b_valid", s_bvalid, 1);
    check("b_id", s_bid, id);
    check("b_resp", s_bresp, rsp);
    @(negedge clk);
    s_bready = 1'b0;
    check("b_done_awready", s_awready, 1);
  endtask

  task automatic drain();
    int n = 0;
    instr_ready = 1'b1;
    while (instr_valid && n < 100) begin @(negedge clk); n++; end
    check("drain_empty", instr_valid, 0);
    check("drain_queue", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; s_awvalid = 0; s_awid = 0; s_awaddr = 0; s_awlen = 0;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_bready = 0; instr_ready = 0;
    @(negedge clk); @(negedge clk);
    check("rst_awready", s_awready, 1);
    check("rst_wready", s_wready, 0);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_bid", s_bid, 0);
    check("rst_bresp", s_bresp, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr_data", instr_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_drop_err", drop_err, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: four-beat burst streamed straight through
    instr_ready = 1'b1;
    aw(12'hABC, 8'd3);
    beat(32'h11, 16'hFFFF, 0); check("t1_lat0", instr_data, 32'h11); check("t1_v0", instr_valid, 1);
    beat(32'h22, 16'hFFFF, 0); check("t1_lat1", instr_data, 32'h22);
    beat(32'h33, 16'hFFFF, 0); check("t1_lat2", instr_data, 32'h33);
    beat(32'h44, 16'hFFFF, 1); check("t1_lat3", instr_data, 32'h44); check("t1_count", fifo_count, 1);
    check("t1_bvalid", s_bvalid, 1);
    resp(12'hABC, 2'b00);
    drain();

    // 2: backpressure with a full FIFO
    instr_ready = 1'b0;
    aw(12'h5A5, 8'd9);
    for (int i = 0; i < 8; i++) beat(32'h100 + i, 16'hFFFF, 0);
    check("t2_full_count", fifo_count, 8);
    check("t2_full_wready", s_wready, 0);
    fork
      begin
        beat(32'h108, 16'hFFFF, 0);
        beat(32'h109, 16'hFFFF, 1);
      end
      begin
        repeat (3) @(negedge clk);
        check("t2_still_blocked", s_wready, 0);
        check("t2_still_full", fifo_count, 8);
        instr_ready = 1'b1;
        @(negedge clk);
        check("t2_wready_after_pop", s_wready, 1);
      end
    join
    resp(12'h5A5, 2'b00);
    drain();

    // 3: partial strobe drops a beat
    instr_ready = 1'b0;
    check("t3_drop_before", drop_err, 0);
    aw(12'h003, 8'd1);
    beat(32'h99, 16'h0000, 0);
    beat(32'h77, 16'hFFFF, 1);
    check("t3_count", fifo_count, 1);
    check("t3_drop_err", drop_err, 1);
    resp(12'h003, 2'b10);
    drain();

    // 4: early wlast, then a clean single-beat burst
    aw(12'h044, 8'd3);
    beat(32'hA1, 16'hFFFF, 0);
    beat(32'hA2, 16'hFFFF, 1);
    check("t4_bvalid_early", s_bvalid, 1);
    resp(12'h044, 2'b10);
    aw(12'h045, 8'd0);
    beat(32'hB1, 16'hFFFF, 1);
    resp(12'h045, 2'b00);
    drain();

    // 5: B held under bready=0
    aw(12'h777, 8'd0);
    beat(32'hC1, 16'hFFFF, 1);
    for (int i = 0; i < 5; i++) begin
      check("t5_bvalid", s_bvalid, 1);
      check("t5_bid", s_bid, 12'h777);
      check("t5_bresp", s_bresp, 0);
      check("t5_awready", s_awready, 0);
      @(negedge clk);
    end
    resp(12'h777, 2'b00);
    drain();

    // 6: reset mid-burst
    instr_ready = 1'b0;
    aw(12'h0D0, 8'd3);
    beat(32'hD1, 16'hFFFF, 0);
    beat(32'hD2, 16'hFFFF, 0);
    check("t6_count_pre", fifo_count, 2);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("t6_count", fifo_count, 0);
    check("t6_instr_valid", instr_valid, 0);
    check("t6_bvalid", s_bvalid, 0);
    check("t6_awready", s_awready, 1);
    check("t6_wready", s_wready, 0);
    check("t6_drop_err", drop_err, 0);
    reset = 1'b0;
    @(negedge clk);
    aw(12'h0E0, 8'd0);
    beat(32'hE1, 16'hFFFF, 1);
    check("t6_after_data", instr_data, 32'hE1);
    resp(12'h0E0, 2'b00);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
